// File: rtl/vram_host_ctrl.sv
// Host-side controller for the dual-port VRAM host port.
// A 4-register, 8-bit asynchronous microcontroller bus is synchronized into
// the dot-clock domain; writes, auto-incrementing address updates and read
// prefetches are sequenced onto the VRAM host port.
//
// Bus strobe semantics: wr = ~nBusCs & ~nBusWr acts once on its synchronized
// assertion (busRs/busDataIn sampled in that cycle); rd = ~nBusCs & ~nBusRd
// acts once on its synchronized deassertion using the busRs value captured
// when the synchronized strobe asserted. The host keeps each strobe low for at
// least 4 clocks with busRs/busDataIn stable over that window. hostSelect is a
// one-cycle strobe qualified by hostRd; read data returns the following cycle.
module vram_host_ctrl #(
  parameter int ADDR_W      = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              nBusCs,
  input  logic              nBusWr,
  input  logic              nBusRd,
  input  logic [1:0]        busRs,
  input  logic [7:0]        busDataIn,
  output logic [7:0]        busDataOut,
  output logic              busDataOe,
  output logic [ADDR_W-1:0] hostAddr,
  output logic [7:0]        hostWrData,
  output logic              hostSelect,
  output logic              hostRd,
  input  logic [7:0]        hostRdData,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WR       = 2'd1;
  localparam logic [1:0] ST_PF_ISSUE = 2'd2;
  localparam logic [1:0] ST_PF_WAIT  = 2'd3;

  localparam logic [1:0] RS_ADDR_LO = 2'd0;
  localparam logic [1:0] RS_ADDR_HI = 2'd1;
  localparam logic [1:0] RS_DATA    = 2'd2;
  localparam logic [1:0] RS_STATUS  = 2'd3;

  // Synchronizers carry the active-low strobe so reset leaves them deasserted.
  logic [SYNC_STAGES-1:0] nwr_sync_q, nwr_sync_d;
  logic [SYNC_STAGES-1:0] nrd_sync_q, nrd_sync_d;
  logic                   nwr_last_q, nwr_last_d;
  logic                   nrd_last_q, nrd_last_d;
  logic [1:0]             rd_rs_q, rd_rs_d;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        pf_q, pf_d;
  logic              auto_inc_q, auto_inc_d;
  logic              overrun_q, overrun_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_wr_q, pend_wr_d;
  logic [1:0]        pend_rs_q, pend_rs_d;
  logic [7:0]        pend_data_q, pend_data_d;
  logic [ADDR_W-1:0] host_addr_q, host_addr_d;
  logic [7:0]        host_wr_data_q, host_wr_data_d;
  logic              host_sel_q, host_sel_d;
  logic              host_rd_q, host_rd_d;

  logic              wr_event, rd_event, rd_assert;
  logic [ADDR_W-1:0] addr_inc;
  logic              new_valid, new_wr;
  logic [1:0]        new_rs;
  logic [7:0]        new_data;
  logic              cmd_valid, cmd_wr;
  logic [1:0]        cmd_rs;
  logic [7:0]        cmd_data;

  assign wr_event  = ~nwr_sync_q[SYNC_STAGES-1] &  nwr_last_q;
  assign rd_assert = ~nrd_sync_q[SYNC_STAGES-1] &  nrd_last_q;
  assign rd_event  =  nrd_sync_q[SYNC_STAGES-1] & ~nrd_last_q;
  assign addr_inc  = addr_q + ADDR_W'(auto_inc_q);

  // Strobe synchronizer shift, edge-detect history and read-select capture.
  always_comb begin
    nwr_sync_d = {nwr_sync_q[SYNC_STAGES-2:0], nBusCs | nBusWr};
    nrd_sync_d = {nrd_sync_q[SYNC_STAGES-2:0], nBusCs | nBusRd};
    nwr_last_d = nwr_sync_q[SYNC_STAGES-1];
    nrd_last_d = nrd_sync_q[SYNC_STAGES-1];
    rd_rs_d    = rd_assert ? busRs : rd_rs_q;
  end

  // Event arbitration, pending slot, register effects and access sequencing.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    pf_d           = pf_q;
    auto_inc_d     = auto_inc_q;
    overrun_d      = overrun_q;
    pend_valid_d   = pend_valid_q;
    pend_wr_d      = pend_wr_q;
    pend_rs_d      = pend_rs_q;
    pend_data_d    = pend_data_q;
    host_addr_d    = host_addr_q;
    host_wr_data_d = host_wr_data_q;
    host_sel_d     = 1'b0;
    host_rd_d      = 1'b1;
    new_valid      = 1'b0;
    new_wr         = 1'b0;
    new_rs         = busRs;
    new_data       = busDataIn;
    cmd_valid      = 1'b0;
    cmd_wr         = 1'b0;
    cmd_rs         = RS_ADDR_LO;
    cmd_data       = 8'h00;

    // A write wins over a coincident read; the lost read counts as overrun.
    // STATUS reads act at once; only DATA reads carry side effects to queue.
    if (wr_event) begin
      new_valid = 1'b1;
      new_wr    = 1'b1;
      if (rd_event) overrun_d = 1'b1;
    end else if (rd_event) begin
      new_rs = rd_rs_q;
      if (rd_rs_q == RS_STATUS) overrun_d = 1'b0;
      else if (rd_rs_q == RS_DATA) new_valid = 1'b1;
    end

    // In IDLE the pending slot goes first and frees room for a new event.
    if (state_q == ST_IDLE) begin
      if (pend_valid_q) begin
        cmd_valid    = 1'b1;
        cmd_wr       = pend_wr_q;
        cmd_rs       = pend_rs_q;
        cmd_data     = pend_data_q;
        pend_valid_d = new_valid;
        if (new_valid) begin
          pend_wr_d   = new_wr;
          pend_rs_d   = new_rs;
          pend_data_d = new_data;
        end
      end else if (new_valid) begin
        cmd_valid = 1'b1;
        cmd_wr    = new_wr;
        cmd_rs    = new_rs;
        cmd_data  = new_data;
      end
    end else if (new_valid) begin
      if (pend_valid_q) begin
        overrun_d = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_wr_d    = new_wr;
        pend_rs_d    = new_rs;
        pend_data_d  = new_data;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_rs)
            RS_ADDR_LO: if (cmd_wr) begin
              addr_d[7:0] = cmd_data;
              state_d     = ST_PF_ISSUE;
            end
            RS_ADDR_HI: if (cmd_wr) begin
              addr_d[ADDR_W-1:8] = cmd_data[ADDR_W-9:0];
              state_d            = ST_PF_ISSUE;
            end
            RS_DATA: begin
              if (cmd_wr) begin
                host_wr_data_d = cmd_data;
                state_d        = ST_WR;
              end else begin
                addr_d  = addr_inc;
                state_d = ST_PF_ISSUE;
              end
            end
            default: if (cmd_wr) auto_inc_d = cmd_data[2];
          endcase
        end
      end
      ST_WR: begin
        addr_d  = addr_inc;
        state_d = ST_PF_ISSUE;
      end
      ST_PF_ISSUE: state_d = ST_PF_WAIT;
      default: begin
        pf_d    = hostRdData;
        state_d = ST_IDLE;
      end
    endcase

    // Host-port strobes are registered so they line up with the state.
    if (state_d == ST_WR) begin
      host_sel_d  = 1'b1;
      host_rd_d   = 1'b0;
      host_addr_d = addr_d;
    end else if (state_d == ST_PF_ISSUE) begin
      host_sel_d  = 1'b1;
      host_addr_d = addr_d;
    end
  end

  // State registers; reset aborts any pending or in-flight access.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      nwr_sync_q     <= '1;
      nrd_sync_q     <= '1;
      nwr_last_q     <= 1'b1;
      nrd_last_q     <= 1'b1;
      rd_rs_q        <= RS_ADDR_LO;
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      pf_q           <= 8'h00;
      auto_inc_q     <= 1'b1;
      overrun_q      <= 1'b0;
      pend_valid_q   <= 1'b0;
      pend_wr_q      <= 1'b0;
      pend_rs_q      <= RS_ADDR_LO;
      pend_data_q    <= 8'h00;
      host_addr_q    <= '0;
      host_wr_data_q <= 8'h00;
      host_sel_q     <= 1'b0;
      host_rd_q      <= 1'b1;
    end else begin
      nwr_sync_q     <= nwr_sync_d;
      nrd_sync_q     <= nrd_sync_d;
      nwr_last_q     <= nwr_last_d;
      nrd_last_q     <= nrd_last_d;
      rd_rs_q        <= rd_rs_d;
      state_q        <= state_d;
      addr_q         <= addr_d;
      pf_q           <= pf_d;
      auto_inc_q     <= auto_inc_d;
      overrun_q      <= overrun_d;
      pend_valid_q   <= pend_valid_d;
      pend_wr_q      <= pend_wr_d;
      pend_rs_q      <= pend_rs_d;
      pend_data_q    <= pend_data_d;
      host_addr_q    <= host_addr_d;
      host_wr_data_q <= host_wr_data_d;
      host_sel_q     <= host_sel_d;
      host_rd_q      <= host_rd_d;
    end
  end

  // Bus read mux is combinational so host reads need no clock.
  always_comb begin
    case (busRs)
      RS_ADDR_LO: busDataOut = addr_q[7:0];
      RS_ADDR_HI: busDataOut = 8'(addr_q[ADDR_W-1:8]);
      RS_DATA:    busDataOut = pf_q;
      default:    busDataOut = {5'b0, auto_inc_q, overrun_q, busy};
    endcase
  end

  assign busDataOe  = ~nBusCs & ~nBusRd;
  assign busy       = (state_q != ST_IDLE);
  assign hostAddr   = host_addr_q;
  assign hostWrData = host_wr_data_q;
  assign hostSelect = host_sel_q;
  assign hostRd     = host_rd_q;

endmodule
